// File: rtl/fb_fill_engine.sv
// fb_fill_engine: rectangle fill writer, one pixel write per cycle, row-major.
// Ports: cmd_* handshake in, stall in, do_write/write_addr/write_data/busy/done out. Macro: FB_FILL_CLIP_EN.
module fb_fill_engine #(
  parameter int FB_WIDTH  = 320,
  parameter int FB_HEIGHT = 200
) (
  input  logic        main_clk,
  input  logic        main_rst_n,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [8:0]  cmd_x,
  input  logic [7:0]  cmd_y,
  input  logic [8:0]  cmd_w,
  input  logic [7:0]  cmd_h,
  input  logic [11:0] cmd_color,
  input  logic        stall,
  output logic        do_write,
  output logic [15:0] write_addr,
  output logic [11:0] write_data,
  output logic        busy,
  output logic        done
);

  if (FB_WIDTH * FB_HEIGHT > 65536) begin : g_size_chk
    $error("framebuffer exceeds 16-bit address space");
  end

  localparam logic [15:0] W16 = 16'(FB_WIDTH);

  typedef enum logic {IDLE, RUN} state_t;

  state_t      state_q, state_d;
  logic [9:0]  x_q, xe_q;
  logic [8:0]  x0_q;
  logic [8:0]  y_q, ye_q;
  logic [15:0] base_q;
  logic [11:0] color_q;
  logic        empty_q;

  logic [9:0]  x_sum, x_end, x_nxt;
  logic [8:0]  y_sum, y_end, y_nxt;
  logic [15:0] row_base;
  logic        empty, last_col, last_pix;
  logic        fire, fin, accept;

  assign x_sum = {1'b0, cmd_x} + {1'b0, cmd_w};
  assign y_sum = {1'b0, cmd_y} + {1'b0, cmd_h};

`ifdef FB_FILL_CLIP_EN
  localparam logic [9:0] XW = 10'(FB_WIDTH);
  localparam logic [8:0] YH = 9'(FB_HEIGHT);
  assign x_end = (x_sum > XW) ? XW : x_sum;
  assign y_end = (y_sum > YH) ? YH : y_sum;
`else
  assign x_end = x_sum;
  assign y_end = y_sum;
`endif

  // Covers zero width/height and, when clipping, an origin off-screen.
  assign empty = (x_end <= {1'b0, cmd_x}) ||
                 (y_end <= {1'b0, cmd_y});

  // Constant shift-add of cmd_y * FB_WIDTH; for 320 this is (y<<8)+(y<<6).
  always_comb begin
    row_base = '0;
    for (int i = 0; i < 16; i++) begin
      if (W16[i]) row_base = row_base + (16'(cmd_y) << i);
    end
  end

  assign x_nxt    = x_q + 10'd1;
  assign y_nxt    = y_q + 9'd1;
  assign last_col = (x_nxt == xe_q);
  assign last_pix = last_col && (y_nxt == ye_q);

  assign fire = (state_q == RUN) && !stall;
  assign fin  = fire && last_pix;

  // Ready looks ahead to the final-write edge so back-to-back
  // commands stream without a bubble.
  assign cmd_ready = (state_q == IDLE) || fin;
  assign accept    = cmd_valid && cmd_ready;
  assign busy      = (state_q == RUN);

  always_comb begin
    state_d = state_q;
    if (fin) state_d = IDLE;
    if (accept) state_d = empty ? IDLE : RUN;
  end

  always_ff @(posedge main_clk or negedge main_rst_n) begin
    if (!main_rst_n) begin
      state_q    <= IDLE;
      x_q        <= '0;
      xe_q       <= '0;
      x0_q       <= '0;
      y_q        <= '0;
      ye_q       <= '0;
      base_q     <= '0;
      color_q    <= '0;
      empty_q    <= 1'b0;
      do_write   <= 1'b0;
      write_addr <= '0;
      write_data <= '0;
      done       <= 1'b0;
    end else begin
      state_q  <= state_d;
      do_write <= fire;
      done     <= fin || empty_q;
      empty_q  <= accept && empty;
      if (fire) begin
        write_addr <= base_q + {6'd0, x_q};
        write_data <= color_q;
      end
      if (accept) begin
        x_q     <= {1'b0, cmd_x};
        x0_q    <= cmd_x;
        xe_q    <= x_end;
        y_q     <= {1'b0, cmd_y};
        ye_q    <= y_end;
        base_q  <= row_base;
        color_q <= cmd_color;
      end else if (fire && !last_pix) begin
        if (last_col) begin
          x_q    <= {1'b0, x0_q};
          y_q    <= y_nxt;
          base_q <= base_q + W16;
        end else begin
          x_q <= x_nxt;
        end
      end
    end
  end

endmodule

// File: tb/tb_fb_fill_engine.sv
// tb_fb_fill_engine: directed bench for fb_fill_engine.
// Writes are collected at the falling edge and compared to hand-computed addresses.
module tb_fb_fill_engine;

  logic        main_clk = 1'b0;
  logic        main_rst_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [8:0]  cmd_x = '0;
  logic [7:0]  cmd_y = '0;
  logic [8:0]  cmd_w = '0;
  logic [7:0]  cmd_h = '0;
  logic [11:0] cmd_color = '0;
  logic        stall = 1'b0;
  logic        do_write;
  logic [15:0] write_addr;
  logic [11:0] write_data;
  logic        busy;
  logic        done;

  int errors = 0;
  int checks = 0;
  logic [15:0] wq[$];
  logic [11:0] dq[$];

  fb_fill_engine dut (
    .main_clk   (main_clk),
    .main_rst_n (main_rst_n),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .cmd_x      (cmd_x),
    .cmd_y      (cmd_y),
    .cmd_w      (cmd_w),
    .cmd_h      (cmd_h),
    .cmd_color  (cmd_color),
    .stall      (stall),
    .do_write   (do_write),
    .write_addr (write_addr),
    .write_data (write_data),
    .busy       (busy),
    .done       (done)
  );

  always #5 main_clk = ~main_clk;

  always @(negedge main_clk) begin
    if (do_write === 1'b1) begin
      wq.push_back(write_addr);
      dq.push_back(write_data);
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] obs,
                       input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge main_clk);
    #1;
  endtask

  task automatic send(input logic [8:0] x, input logic [7:0] y,
                      input logic [8:0] w, input logic [7:0] h,
                      input logic [11:0] c);
    cmd_x = x; cmd_y = y; cmd_w = w; cmd_h = h; cmd_color = c;
    cmd_valid = 1'b1;
    step();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (done !== 1'b1 && n < limit);
  endtask

  initial begin
    #1_500_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    int n;
    int bad;
    int e2[8];
    int e3[$];
    e2 = '{1610, 1611, 1612, 1613, 1930, 1931, 1932, 1933};

    // reset state
    #2;
    check("rst_do_write", do_write, 0);
    check("rst_addr", write_addr, 0);
    check("rst_data", write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    step();
    main_rst_n = 1'b1;
    step();
    check("rst_ready", cmd_ready, 1);

    // 1x1 at (0,0)
    wq.delete(); dq.delete();
    send(9'd0, 8'd0, 9'd1, 8'd1, 12'hF00);
    check("t1_busy_run", busy, 1);
    check("t1_no_early_write", do_write, 0);
    step();
    check("t1_write", do_write, 1);
    check("t1_addr", write_addr, 0);
    check("t1_data", write_data, 12'hF00);
    check("t1_done", done, 1);
    check("t1_busy_off", busy, 0);
    check("t1_ready", cmd_ready, 1);
    step();
    check("t1_done_pulse", done, 0);
    check("t1_write_end", do_write, 0);
    check("t1_count", wq.size(), 1);

    // 4x2 at (10,5), stall on RUN edges 2 and 3
    wq.delete(); dq.delete();
    send(9'd10, 8'd5, 9'd4, 8'd2, 12'h0A5);
    cmd_x = 9'd100; cmd_w = 9'd1; cmd_color = 12'hFFF;
    step();
    check("t2_first_write", do_write, 1);
    check("t2_first_addr", write_addr, 1610);
    stall = 1'b1;
    step();
    check("t2_stalled", do_write, 0);
    check("t2_busy_stalled", busy, 1);
    step();
    stall = 1'b0;
    wait_done(40, n);
    check("t2_done", done, 1);
    check("t2_cycles", 3 + n, 10);
    step();
    check("t2_count", wq.size(), 8);
    for (int i = 0; i < 8; i++) begin
      check("t2_addr", (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, e2[i]);
    end
    bad = 0;
    foreach (dq[i]) if (dq[i] !== 12'h0A5) bad++;
    check("t2_data", bad, 0);

    // 3x2 at (318,199): clipped or aliased
    wq.delete(); dq.delete();
`ifdef FB_FILL_CLIP_EN
    e3 = '{63998, 63999};
`else
    e3 = '{63998, 63999, 64000, 64318, 64319, 64320};
`endif
    send(9'd318, 8'd199, 9'd3, 8'd2, 12'h123);
    wait_done(30, n);
    check("t3_done", done, 1);
    step();
    check("t3_count", wq.size(), e3.size());
    for (int i = 0; i < e3.size(); i++) begin
      check("t3_addr", (i < wq.size()) ? 32'(wq[i]) : 32'hFFFF_FFFF, e3[i]);
    end

    // empty extent: width 0 at (5,5)
    wq.delete(); dq.delete();
    send(9'd5, 8'd5, 9'd0, 8'd3, 12'h777);
    check("t4_busy_e0", busy, 0);
    check("t4_done_e0", done, 0);
    step();
    check("t4_done_e1", done, 1);
    check("t4_busy_e1", busy, 0);
    step();
    check("t4_done_e2", done, 0);
    check("t4_count", wq.size(), 0);

    // full screen then back-to-back 1x1 at (2,0)
    wq.delete(); dq.delete();
    cmd_x = 9'd0; cmd_y = 8'd0; cmd_w = 9'd320; cmd_h = 8'd200;
    cmd_color = 12'h7F7;
    cmd_valid = 1'b1;
    step();
    cmd_x = 9'd2; cmd_y = 8'd0; cmd_w = 9'd1; cmd_h = 8'd1;
    cmd_color = 12'h00F;
    check("t5_busy", busy, 1);
    check("t5_held_off", cmd_ready, 0);
    wait_done(70000, n);
    cmd_valid = 1'b0;
    check("t5_cycles", n, 64000);
    check("t5_last_addr", write_addr, 63999);
    check("t5_last_write", do_write, 1);
    check("t5_done", done, 1);
    check("t5_second_run", busy, 1);
    step();
    check("t5_b2b_write", do_write, 1);
    check("t5_b2b_addr", write_addr, 2);
    check("t5_b2b_data", write_data, 12'h00F);
    check("t5_b2b_done", done, 1);
    step();
    check("t5_done_end", done, 0);
    check("t5_busy_end", busy, 0);
    check("t5_count", wq.size(), 64001);
    bad = 0;
    for (int i = 0; i < 64000 && i < wq.size(); i++) begin
      if (wq[i] !== 16'(i)) bad++;
    end
    check("t5_seq", bad, 0);
    check("t5_tail", (wq.size() > 64000) ? 32'(wq[64000]) : 32'hFFFF_FFFF, 2);

    // reset during the 3rd write of a 10x1 fill at (20,3)
    wq.delete(); dq.delete();
    send(9'd20, 8'd3, 9'd10, 8'd1, 12'h555);
    step();
    step();
    step();
    check("t6_third_addr", write_addr, 982);
    main_rst_n = 1'b0;
    #1;
    check("t6_abort_write", do_write, 0);
    check("t6_abort_addr", write_addr, 0);
    check("t6_abort_data", write_data, 0);
    check("t6_abort_busy", busy, 0);
    check("t6_abort_done", done, 0);
    step();
    step();
    main_rst_n = 1'b1;
    check("t6_ready", cmd_ready, 1);
    check("t6_busy", busy, 0);
    repeat (5) step();
    check("t6_writes", wq.size(), 2);
    check("t6_quiet", do_write, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
